// File: rtl/phy_tx_link_ctrl.sv
// Two-lane PHY TX link sequencer: trains with COM, guards with IDLE, then passes
// payload while the receiver stays in sync; retrains on sync loss or timeout.
module phy_tx_link_ctrl #(
  parameter logic [7:0] COM_SYM    = 8'hBC,
  parameter logic [7:0] IDLE_SYM   = 8'h7C,
  parameter int         TRAIN_SYMS = 4,
  parameter int         IDLE_SYMS  = 2,
  parameter int         TIMEOUT    = 64,
  parameter int         CNT_W      = 8
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       enable,
  input  logic       rx_sync,
  input  logic [7:0] data_in0,
  input  logic       valid_in0,
  input  logic [7:0] data_in1,
  input  logic       valid_in1,
  output logic [7:0] data_out0,
  output logic       valid_out0,
  output logic [7:0] data_out1,
  output logic       valid_out1,
  output logic [1:0] k_char,
  output logic       active,
  output logic [1:0] state,
  output logic       timeout_p
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'b00,
    ST_TRAIN  = 2'b01,
    ST_IDLE   = 2'b10,
    ST_ACTIVE = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] TRAIN_LAST   = CNT_W'(TRAIN_SYMS - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST    = CNT_W'(IDLE_SYMS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data0_d, data1_d;
  logic             valid0_d, valid1_d, active_d, timeout_d;
  logic [1:0]       k_d;

  // NOTE: every signal gets a default at the top so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;

    if (!enable) begin
      state_d = ST_RESET;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_RESET: begin
          state_d = ST_TRAIN;
          cnt_d   = '0;
        end
        ST_TRAIN: begin
          if (rx_sync && cnt_q >= TRAIN_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (!rx_sync && cnt_q == TIMEOUT_LAST) begin
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else if (cnt_q < TIMEOUT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_IDLE: begin
          if (!rx_sync) begin
            state_d = ST_TRAIN;
            cnt_d   = '0;
          end else if (cnt_q >= IDLE_LAST) begin
            state_d = ST_ACTIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_ACTIVE: begin
          cnt_d = '0;
          if (!rx_sync) state_d = ST_TRAIN;
        end
        default: begin
          state_d = ST_RESET;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs follow the state being entered; payload only flows on an edge
    // that both starts and ends in ACTIVE, so nothing leaks on entry or exit.
    data0_d  = COM_SYM;
    data1_d  = COM_SYM;
    valid0_d = 1'b0;
    valid1_d = 1'b0;
    k_d      = 2'b11;
    active_d = 1'b0;
    if (state_d == ST_IDLE) begin
      data0_d = IDLE_SYM;
      data1_d = IDLE_SYM;
    end else if (state_d == ST_ACTIVE) begin
      active_d = 1'b1;
      data0_d  = IDLE_SYM;
      data1_d  = IDLE_SYM;
      if (state_q == ST_ACTIVE && valid_in0) begin
        data0_d  = data_in0;
        valid0_d = 1'b1;
        k_d[0]   = 1'b0;
      end
      if (state_q == ST_ACTIVE && valid_in1) begin
        data1_d  = data_in1;
        valid1_d = 1'b1;
        k_d[1]   = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q    <= ST_RESET;
      cnt_q      <= '0;
      data_out0  <= COM_SYM;
      data_out1  <= COM_SYM;
      valid_out0 <= 1'b0;
      valid_out1 <= 1'b0;
      k_char     <= 2'b11;
      active     <= 1'b0;
      timeout_p  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out0  <= data0_d;
      data_out1  <= data1_d;
      valid_out0 <= valid0_d;
      valid_out1 <= valid1_d;
      k_char     <= k_d;
      active     <= active_d;
      timeout_p  <= timeout_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_phy_tx_link_ctrl.sv
// Bench for phy_tx_link_ctrl: directed vector table, timeout sequence, and a
// randomized run against a symbol-counting reference model.
module tb_phy_tx_link_ctrl;

  localparam int TRAIN_SYMS = 4;
  localparam int IDLE_SYMS  = 2;
  localparam int TIMEOUT    = 64;
  localparam logic [7:0] BC = 8'hBC;
  localparam logic [7:0] IC = 8'h7C;

  logic       clk_4f = 1'b0;
  logic       reset = 1'b1, enable = 1'b0, rx_sync = 1'b0;
  logic [7:0] data_in0 = '0, data_in1 = '0;
  logic       valid_in0 = 1'b0, valid_in1 = 1'b0;
  logic [7:0] data_out0, data_out1;
  logic       valid_out0, valid_out1, active, timeout_p;
  logic [1:0] k_char, state;

  int checks = 0;
  int failures = 0;

  phy_tx_link_ctrl dut (
    .clk_4f(clk_4f), .reset(reset), .enable(enable), .rx_sync(rx_sync),
    .data_in0(data_in0), .valid_in0(valid_in0),
    .data_in1(data_in1), .valid_in1(valid_in1),
    .data_out0(data_out0), .valid_out0(valid_out0),
    .data_out1(data_out1), .valid_out1(valid_out1),
    .k_char(k_char), .active(active), .state(state), .timeout_p(timeout_p)
  );

  always #5 clk_4f = ~clk_4f;

  // Packed view: {state, active, timeout_p, k_char, valid1, valid0, data1, data0}
  function automatic logic [23:0] dut_vec();
    return {state, active, timeout_p, k_char, valid_out1, valid_out0, data_out1, data_out0};
  endfunction

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: tracks link phase plus how many COM / IDLE cycles have
  // been emitted in the current training run, and predicts the next output.
  localparam int P_OFF = 0, P_TRAIN = 1, P_GUARD = 2, P_UP = 3;
  int          m_phase = P_OFF;
  int          m_coms = 0;
  int          m_guards = 0;
  logic [23:0] m_exp;

  task automatic model_step(input bit rst, input bit en, input bit rs,
                            input bit v0, input logic [7:0] d0,
                            input bit v1, input logic [7:0] d1);
    bit was_up;
    bit pulse;
    logic [7:0] o0, o1;
    bit ov0, ov1;
    was_up = (m_phase == P_UP);
    pulse  = 1'b0;
    if (rst || !en) begin
      m_phase = P_OFF;
    end else begin
      case (m_phase)
        P_OFF: begin m_phase = P_TRAIN; m_coms = 1; end
        P_TRAIN: begin
          if (rs && m_coms >= TRAIN_SYMS) begin m_phase = P_GUARD; m_guards = 1; end
          else if (!rs && m_coms == TIMEOUT) begin m_coms = 1; pulse = 1'b1; end
          else if (m_coms < TIMEOUT) m_coms++;
        end
        P_GUARD: begin
          if (!rs) begin m_phase = P_TRAIN; m_coms = 1; end
          else if (m_guards >= IDLE_SYMS) m_phase = P_UP;
          else m_guards++;
        end
        default: if (!rs) begin m_phase = P_TRAIN; m_coms = 1; end
      endcase
    end
    o0 = (m_phase >= P_GUARD) ? IC : BC;
    o1 = o0;
    ov0 = was_up && m_phase == P_UP && v0;
    ov1 = was_up && m_phase == P_UP && v1;
    if (ov0) o0 = d0;
    if (ov1) o1 = d1;
    m_exp = {2'(m_phase), m_phase == P_UP, pulse, !ov1, !ov0, ov1, ov0, o1, o0};
  endtask

  task automatic cycle(input bit rst, input bit en, input bit rs,
                       input bit v0, input logic [7:0] d0,
                       input bit v1, input logic [7:0] d1);
    reset = rst; enable = en; rx_sync = rs;
    valid_in0 = v0; data_in0 = d0; valid_in1 = v1; data_in1 = d1;
    model_step(rst, en, rs, v0, d0, v1, d1);
    @(posedge clk_4f);
    #1;
  endtask

  typedef struct {
    bit rst, en, rs, v0; logic [7:0] d0; bit v1; logic [7:0] d1;
    logic [1:0] e_state; bit e_act; logic [1:0] e_k; bit e_v0, e_v1;
    logic [7:0] e_d0, e_d1;
  } vec_t;

  function automatic vec_t mk(bit rst, bit en, bit rs, bit v0, logic [7:0] d0, bit v1,
                              logic [7:0] d1, logic [1:0] st, bit act, logic [1:0] k,
                              bit ev0, bit ev1, logic [7:0] ed0, logic [7:0] ed1);
    vec_t v;
    v = '{rst, en, rs, v0, d0, v1, d1, st, act, k, ev0, ev1, ed0, ed1};
    return v;
  endfunction

  vec_t tbl[38];

  initial begin
    int n_rand;
    int sync_off;
    // Scenario 1: reset 3 cycles, then 4xCOM, 2xIDLE, ACTIVE on the 7th output cycle.
    for (int i = 0; i < 3; i++) tbl[i] = mk(1, i > 0, i > 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 0, 0, BC, BC);
    for (int i = 3; i < 7; i++) tbl[i] = mk(0, 1, 1, 0, 0, 0, 0, 2'b01, 0, 2'b11, 0, 0, BC, BC);
    tbl[7]  = mk(0, 1, 1, 0, 0, 0, 0, 2'b10, 0, 2'b11, 0, 0, IC, IC);
    tbl[8]  = mk(0, 1, 1, 0, 0, 0, 0, 2'b10, 0, 2'b11, 0, 0, IC, IC);
    tbl[9]  = mk(0, 1, 1, 0, 0, 0, 0, 2'b11, 1, 2'b11, 0, 0, IC, IC);
    // Scenario 2 and per-lane independence, including payload equal to K symbols.
    tbl[10] = mk(0, 1, 1, 1, 8'hA5, 0, 8'h33, 2'b11, 1, 2'b10, 1, 0, 8'hA5, IC);
    tbl[11] = mk(0, 1, 1, 1, BC, 1, IC, 2'b11, 1, 2'b00, 1, 1, BC, IC);
    tbl[12] = mk(0, 1, 1, 0, 8'h99, 1, 8'h5A, 2'b11, 1, 2'b01, 0, 1, IC, 8'h5A);
    // Scenario 4: one-cycle sync loss drops payload, then full retrain.
    tbl[13] = mk(0, 1, 0, 1, 8'h11, 1, 8'h22, 2'b01, 0, 2'b11, 0, 0, BC, BC);
    for (int i = 14; i < 17; i++) tbl[i] = mk(0, 1, 1, 1, 8'h44, 1, 8'h55, 2'b01, 0, 2'b11, 0, 0, BC, BC);
    tbl[17] = mk(0, 1, 1, 0, 0, 0, 0, 2'b10, 0, 2'b11, 0, 0, IC, IC);
    tbl[18] = mk(0, 1, 1, 0, 0, 0, 0, 2'b10, 0, 2'b11, 0, 0, IC, IC);
    tbl[19] = mk(0, 1, 1, 0, 0, 0, 0, 2'b11, 1, 2'b11, 0, 0, IC, IC);
    // Scenario 5: enable drop in ACTIVE and in TRAIN.
    tbl[20] = mk(0, 0, 1, 1, 8'h66, 1, 8'h77, 2'b00, 0, 2'b11, 0, 0, BC, BC);
    tbl[21] = mk(0, 1, 1, 0, 0, 0, 0, 2'b01, 0, 2'b11, 0, 0, BC, BC);
    tbl[22] = mk(0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b11, 0, 0, BC, BC);
    for (int i = 23; i < 27; i++) tbl[i] = mk(0, 1, 1, 0, 0, 0, 0, 2'b01, 0, 2'b11, 0, 0, BC, BC);
    tbl[27] = mk(0, 1, 1, 0, 0, 0, 0, 2'b10, 0, 2'b11, 0, 0, IC, IC);
    tbl[28] = mk(0, 1, 1, 0, 0, 0, 0, 2'b10, 0, 2'b11, 0, 0, IC, IC);
    tbl[29] = mk(0, 1, 1, 0, 0, 0, 0, 2'b11, 1, 2'b11, 0, 0, IC, IC);
    // Scenario 6: reset mid-ACTIVE with payload present.
    tbl[30] = mk(1, 1, 1, 1, 8'h11, 1, 8'h22, 2'b00, 0, 2'b11, 0, 0, BC, BC);
    for (int i = 31; i < 35; i++) tbl[i] = mk(0, 1, 1, 0, 0, 0, 0, 2'b01, 0, 2'b11, 0, 0, BC, BC);
    tbl[35] = mk(0, 1, 1, 0, 0, 0, 0, 2'b10, 0, 2'b11, 0, 0, IC, IC);
    // Sync loss during the IDLE guard falls back to TRAIN.
    tbl[36] = mk(0, 1, 0, 0, 0, 0, 0, 2'b01, 0, 2'b11, 0, 0, BC, BC);
    tbl[37] = mk(0, 1, 0, 0, 0, 0, 0, 2'b01, 0, 2'b11, 0, 0, BC, BC);

    for (int i = 0; i < 38; i++) begin
      cycle(tbl[i].rst, tbl[i].en, tbl[i].rs, tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1);
      check($sformatf("vec%0d", i), dut_vec(),
            {tbl[i].e_state, tbl[i].e_act, 1'b0, tbl[i].e_k, tbl[i].e_v1, tbl[i].e_v0,
             tbl[i].e_d1, tbl[i].e_d0});
    end

    // Scenario 3: rx_sync held low; timeout pulses on TRAIN output cycles 65, 129, 193.
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    for (int n = 1; n <= 200; n++) begin
      bit exp_to;
      cycle(0, 1, 0, 0, 0, 0, 0);
      exp_to = (n == 65) || (n == 129) || (n == 193);
      check($sformatf("timeout_n%0d", n), {20'h0, state, active, timeout_p},
            {20'h0, 2'b01, 1'b0, exp_to});
      check($sformatf("timeout_bc_n%0d", n), {8'h0, data_out1, data_out0}, {8'h0, BC, BC});
    end

    // Randomized run against the reference model, with long sync-off bursts.
    sync_off = 0;
    n_rand = 4000;
    for (int i = 0; i < n_rand; i++) begin
      bit rst, en, rs;
      if (sync_off == 0 && $urandom_range(0, 99) == 0) sync_off = $urandom_range(1, 150);
      rs  = (sync_off == 0) && ($urandom_range(0, 39) != 0);
      if (sync_off > 0) sync_off--;
      rst = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 79) != 0);
      cycle(rst, en, rs, 1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom));
      check($sformatf("rand%0d", i), dut_vec(), m_exp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
